// File: rtl/fetal_ecg_pkg.sv
// fetal_ecg_pkg: state encoding and widths shared by the covariance builder and the eigen chain
package fetal_ecg_pkg;
  typedef enum logic [1:0] {COLLECT, MAC, FINAL, PRESENT} cov_state_t;
  localparam int SIZE_N_DEFAULT = 8;
  localparam int COV_W = 32;
endpackage

// File: rtl/cov_matrix_builder_if.sv
// cov_matrix_builder_if: sample stream in, covariance matrix out with valid/ack
interface cov_matrix_builder_if import fetal_ecg_pkg::*; #(
  parameter int SIZE_N = SIZE_N_DEFAULT,
  parameter int DATA_W = 16
) ();
  logic sample_valid;
  logic sample_ready;
  logic signed [DATA_W-1:0] sample_data [SIZE_N];
  logic cov_valid;
  logic cov_ack;
  logic signed [COV_W-1:0] cov_matrix [SIZE_N][SIZE_N];
  logic sat_flag;
  logic busy;
  modport master (output sample_valid, sample_data, cov_ack,
                  input sample_ready, cov_valid, cov_matrix, sat_flag, busy);
  modport slave (input sample_valid, sample_data, cov_ack,
                 output sample_ready, cov_valid, cov_matrix, sat_flag, busy);
endinterface

// File: rtl/cov_finalise_unit.sv
// cov_finalise_unit: mean-removed covariance from first/second moments, saturated to COV_W
module cov_finalise_unit import fetal_ecg_pkg::*; #(
  parameter int ACC_W = 40,
  parameter int LOG2_WINDOW = 8
) (
  input  logic signed [ACC_W-1:0] s_ij,
  input  logic signed [ACC_W-1:0] s_i,
  input  logic signed [ACC_W-1:0] s_j,
  output logic signed [COV_W-1:0] c,
  output logic sat
);
  localparam int PW = 2*ACC_W + 1;
  localparam logic signed [PW-1:0] MAX = PW'($signed({1'b0, {(COV_W-1){1'b1}}}));
  localparam logic signed [PW-1:0] MIN = PW'($signed({1'b1, {(COV_W-1){1'b0}}}));
  logic signed [PW-1:0] prod, full;
  assign prod = PW'(s_i) * PW'(s_j);
  assign full = (PW'(s_ij) - (prod >>> LOG2_WINDOW)) >>> LOG2_WINDOW;
  assign sat = full > MAX || full < MIN;
  assign c = full > MAX ? MAX[COV_W-1:0] : full < MIN ? MIN[COV_W-1:0] : full[COV_W-1:0];
endmodule

// File: rtl/cov_matrix_builder.sv
// cov_matrix_builder: windowed moment accumulation and covariance matrix presentation
module cov_matrix_builder import fetal_ecg_pkg::*; #(
  parameter int SIZE_N = SIZE_N_DEFAULT,
  parameter int LOG2_WINDOW = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W = 2*DATA_W + LOG2_WINDOW
) (
  input logic clk,
  input logic rst,
  cov_matrix_builder_if.slave bus
);
  localparam int RW = SIZE_N > 1 ? $clog2(SIZE_N) : 1;
  localparam logic [RW-1:0] LAST = RW'(SIZE_N - 1);
  localparam logic [LOG2_WINDOW:0] WINDOW = {1'b1, {LOG2_WINDOW{1'b0}}};
  cov_state_t state, state_nx;
  logic [LOG2_WINDOW:0] cnt;
  logic [RW-1:0] r, fi, fj;
  logic signed [DATA_W-1:0] x [SIZE_N];
  logic signed [ACC_W-1:0] s [SIZE_N];
  logic signed [ACC_W-1:0] sx [SIZE_N][SIZE_N];
  logic signed [COV_W-1:0] c;
  logic sat, take;
  assign bus.sample_ready = state == COLLECT;
  assign bus.busy = state != COLLECT;
  assign take = bus.sample_valid && bus.sample_ready;
  cov_finalise_unit #(.ACC_W(ACC_W), .LOG2_WINDOW(LOG2_WINDOW)) u_fin (
    .s_ij(sx[fi][fj]), .s_i(s[fi]), .s_j(s[fj]), .c(c), .sat(sat)
  );
  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: state_nx = take ? MAC : COLLECT;
      MAC:     state_nx = r != LAST ? MAC : cnt == WINDOW ? FINAL : COLLECT;
      FINAL:   state_nx = fi == LAST && fj == LAST ? PRESENT : FINAL;
      PRESENT: state_nx = bus.cov_ack ? COLLECT : PRESENT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= COLLECT;
      cnt <= '0;
      r <= '0;
      fi <= '0;
      fj <= '0;
      x <= '{default: '0};
      s <= '{default: '0};
      sx <= '{default: '0};
      bus.cov_matrix <= '{default: '0};
      bus.cov_valid <= 1'b0;
      bus.sat_flag <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        COLLECT: if (take) begin
          x <= bus.sample_data;
          cnt <= cnt + 1'b1;
          r <= '0;
        end
        MAC: begin
          s[r] <= s[r] + ACC_W'(x[r]);
          for (int j = 0; j < SIZE_N; j++)
            if (j >= int'(r)) sx[r][j] <= sx[r][j] + ACC_W'(x[r]) * ACC_W'(x[j]);
          r <= r + 1'b1;
          fi <= '0;
          fj <= '0;
        end
        FINAL: begin
          bus.cov_matrix[fi][fj] <= c;
          bus.cov_matrix[fj][fi] <= c;
          bus.sat_flag <= bus.sat_flag | sat;
          fi <= fj == LAST ? fi + 1'b1 : fi;
          fj <= fj == LAST ? fi + 1'b1 : fj + 1'b1;
          if (fi == LAST && fj == LAST) bus.cov_valid <= 1'b1;
        end
        PRESENT: if (bus.cov_ack) begin
          bus.cov_valid <= 1'b0;
          bus.sat_flag <= 1'b0;
          cnt <= '0;
          s <= '{default: '0};
          sx <= '{default: '0};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cov_matrix_builder.sv
// tb_cov_matrix_builder: directed checks on a 2-channel and an 8-channel builder, 4-sample windows
module tb_cov_matrix_builder;
  import fetal_ecg_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int bx [4][8];
  int gaps [4] = '{0, 3, 0, 2};
  int n;
  logic acc;
  longint si, sj, sij, e;
  cov_matrix_builder_if #(.SIZE_N(2), .DATA_W(24)) ia ();
  cov_matrix_builder_if #(.SIZE_N(8), .DATA_W(16)) ib ();
  cov_matrix_builder #(.SIZE_N(2), .LOG2_WINDOW(2), .DATA_W(24)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  cov_matrix_builder #(.SIZE_N(8), .LOG2_WINDOW(2), .DATA_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  task automatic check(input string tag, input logic signed [63:0] got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic send_a(input int a0, input int a1);
    int k = 0;
    while (!ia.sample_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("send_a_ready", ia.sample_ready, 1);
    ia.sample_valid = 1'b1;
    ia.sample_data[0] = 24'(a0);
    ia.sample_data[1] = 24'(a1);
    @(negedge clk);
    ia.sample_valid = 1'b0;
  endtask
  task automatic wait_a(input int exp_lat);
    int k = 0;
    while (!ia.cov_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("a_latency", k, exp_lat);
    @(negedge clk);
  endtask
  task automatic chk_a(input string tag, input longint e00, input longint e01,
                       input longint e10, input longint e11, input longint esat);
    check({tag, "_c00"}, ia.cov_matrix[0][0], e00);
    check({tag, "_c01"}, ia.cov_matrix[0][1], e01);
    check({tag, "_c10"}, ia.cov_matrix[1][0], e10);
    check({tag, "_c11"}, ia.cov_matrix[1][1], e11);
    check({tag, "_sat"}, ia.sat_flag, esat);
  endtask
  task automatic ack_a;
    ia.cov_ack = 1'b1;
    @(posedge clk);
    #1;
    check("ack_valid", ia.cov_valid, 0);
    check("ack_ready", ia.sample_ready, 1);
    @(negedge clk);
    ia.cov_ack = 1'b0;
  endtask
  initial begin
    ia.sample_valid = 1'b0;
    ia.cov_ack = 1'b0;
    ia.sample_data = '{default: '0};
    ib.sample_valid = 1'b0;
    ib.cov_ack = 1'b0;
    ib.sample_data = '{default: '0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ia.cov_valid, 0);
    check("rst_sat", ia.sat_flag, 0);
    check("rst_busy", ia.busy, 0);
    check("rst_ready", ia.sample_ready, 1);
    check("rst_c00", ia.cov_matrix[0][0], 0);
    check("rst_b_c77", ib.cov_matrix[7][7], 0);
    @(negedge clk);
    rst = 1'b1;
    send_a(2, 1); send_a(-2, 1); send_a(2, 1); send_a(-2, 1);
    wait_a(5);
    chk_a("t1", 4, 0, 0, 0, 0);
    check("t1_busy", ia.busy, 1);
    // samples offered while presenting must be ignored
    ia.sample_valid = 1'b1;
    ia.sample_data[0] = 24'(100);
    ia.sample_data[1] = -24'(100);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_ready", ia.sample_ready, 0);
      check("hold_valid", ia.cov_valid, 1);
      check("hold_c00", ia.cov_matrix[0][0], 4);
    end
    @(negedge clk);
    ia.sample_valid = 1'b0;
    ack_a;
    check("keep_c00", ia.cov_matrix[0][0], 4);
    send_a(3, 3); send_a(1, 1); send_a(3, 3); send_a(1, 1);
    wait_a(5);
    chk_a("t2", 1, 1, 1, 1, 0);
    ack_a;
    send_a(8388607, 0); send_a(-8388607, 0); send_a(8388607, 0); send_a(-8388607, 0);
    wait_a(5);
    chk_a("sat", 2147483647, 0, 0, 0, 1);
    ack_a;
    check("sat_clr", ia.sat_flag, 0);
    send_a(50, -50); send_a(7, 9);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_valid", ia.cov_valid, 0);
    check("mrst_busy", ia.busy, 0);
    check("mrst_sat", ia.sat_flag, 0);
    check("mrst_c00", ia.cov_matrix[0][0], 0);
    @(negedge clk);
    rst = 1'b1;
    send_a(2, 1); send_a(-2, 1); send_a(2, 1); send_a(-2, 1);
    wait_a(5);
    chk_a("t5", 4, 0, 0, 0, 0);
    ack_a;
    for (int k = 0; k < 4; k++)
      for (int ch = 0; ch < 8; ch++)
        bx[k][ch] = (k + 1) * (ch - 3) * 1500 + ((k % 2 == 1) ? 211 : -130);
    for (int k = 0; k < 4; k++) begin
      repeat (gaps[k]) @(negedge clk);
      ib.sample_valid = 1'b1;
      for (int ch = 0; ch < 8; ch++) ib.sample_data[ch] = 16'(bx[k][ch]);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
        acc = ib.sample_ready;
        @(negedge clk);
        n++;
      end
      check("b_accept", acc, 1);
      ib.sample_valid = 1'b0;
    end
    n = 0;
    while (!ib.cov_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b_latency", n, 44);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        si = 0; sj = 0; sij = 0;
        for (int k = 0; k < 4; k++) begin
          si += bx[k][i];
          sj += bx[k][j];
          sij += longint'(bx[k][i]) * bx[k][j];
        end
        e = (sij - ((si * sj) >>> 2)) >>> 2;
        check($sformatf("b_c%0d%0d", i, j), ib.cov_matrix[i][j], e);
      end
    check("b_sat", ib.sat_flag, 0);
    @(negedge clk);
    ib.cov_ack = 1'b1;
    @(posedge clk);
    #1;
    check("b_ack_valid", ib.cov_valid, 0);
    @(negedge clk);
    ib.cov_ack = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
